mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: ADDR_W, 8, word address width into shared memory.
REQ-002 Parameter: DATA_W, 32, data width.
REQ-003 Parameter: TIMEOUT, 15, max cycles waiting for mem_valid; legal range 1..255.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 if_request / if_we_re / if_mask / if_address / if_data_in  in  1/1/4/ADDR_W/DATA_W  fetch-side request bundle.
REQ-007 if_valid / if_err / if_data_out  out  1/1/DATA_W  fetch-side completion strobe, timeout flag, read data.
REQ-008 dm_request / dm_we_re / dm_mask / dm_address / dm_data_in  in  1/1/4/ADDR_W/DATA_W  data-side request bundle.
REQ-009 dm_valid / dm_err / dm_data_out  out  1/1/DATA_W  data-side completion strobe, timeout flag, read data.
REQ-010 mem_request / mem_we_re / mem_mask / mem_address / mem_data_in  out  1/1/4/ADDR_W/DATA_W  shared memory command, registered.
REQ-011 mem_valid / mem_data_out  in  1/DATA_W  shared memory completion and read data.

Function
REQ-012 FSM SHALL have states IDLE, BUSY_IF, BUSY_DM.
REQ-013 In IDLE with any request high, arbiter SHALL pick a winner, latch its bundle into mem_* registers, set mem_request=1, enter BUSY_<winner> at next edge.
REQ-014 In IDLE with no request, FSM SHALL stay IDLE with mem_request=0.
REQ-015 mem_* bundle SHALL remain stable throughout BUSY; requester inputs changing during BUSY SHALL be ignored.
REQ-016 In BUSY_x with mem_valid=1, x_valid SHALL be 1 that same cycle (combinational), x_data_out=mem_data_out, x_err=0; next state IDLE, mem_request=0.
REQ-017 Non-granted port's valid SHALL be 0 at all times; its data_out SHALL be 0.
REQ-018 Wait counter SHALL clear on entering BUSY and increment each BUSY cycle without mem_valid; when it reaches TIMEOUT, arbiter SHALL pulse x_valid=1 and x_err=1 for one cycle, with x_data_out=0, then return to IDLE.
REQ-019 mem_valid and timeout in the same cycle: mem_valid SHALL win (err=0).
REQ-020 mem_valid while IDLE SHALL be ignored.
REQ-021 Minimum grant-to-grant spacing SHALL be one IDLE cycle; requesters SHALL drop request the cycle after their valid, otherwise a repeat transaction is granted.
REQ-022 Requester bundles SHALL NOT pass combinationally to mem_*; latency request-to-mem_request is exactly 1 cycle.

Reset
REQ-023 On rst=1, independent of clk: state=IDLE, counter=0, all mem_* outputs 0, if_/dm_ valid, err, data_out 0, priority pointer=DM.
REQ-024 Reset asserted mid-BUSY SHALL abort the transaction; no valid pulse SHALL be produced for it after reset release.

Configuration
REQ-025 Macro ARB_RR_EN defined: round-robin; on simultaneous requests the port not granted last wins; pointer updates on each grant.
REQ-026 ARB_RR_EN undefined: fixed priority, DM always wins simultaneous requests; pointer logic absent.

Verification
REQ-027 Single IF read addr 0x04, memory replies 2 cycles after mem_request with 0x00500093 -> mem_request at cycle 1, if_valid=1 and if_data_out=0x00500093 at cycle 3, dm_valid stays 0.
REQ-028 IF and DM request together, same cycle, DM write 0xDEADBEEF mask 0xF addr 0x10 -> DM granted first (both modes, pointer=DM after reset); IF granted after one IDLE cycle.
REQ-029 With ARB_RR_EN, both ports request continuously for 4 transactions -> grant order DM, IF, DM, IF; without it -> DM, DM, DM, DM.
REQ-030 TIMEOUT=15, memory never responds -> dm_valid=1, dm_err=1 exactly 15 BUSY cycles after grant; FSM back to IDLE next cycle.
REQ-031 rst pulsed during BUSY_IF, then memory asserts mem_valid -> no if_valid, mem_request=0, state IDLE.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Request/completion bundle shared by the fetch port, the data port and the
// single shared memory behind mem_arbiter.
interface mem_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  logic              if_request;
  logic              if_we_re;
  logic [3:0]        if_mask;
  logic [ADDR_W-1:0] if_address;
  logic [DATA_W-1:0] if_data_in;
  logic              if_valid;
  logic              if_err;
  logic [DATA_W-1:0] if_data_out;

  logic              dm_request;
  logic              dm_we_re;
  logic [3:0]        dm_mask;
  logic [ADDR_W-1:0] dm_address;
  logic [DATA_W-1:0] dm_data_in;
  logic              dm_valid;
  logic              dm_err;
  logic [DATA_W-1:0] dm_data_out;

  logic              mem_request;
  logic              mem_we_re;
  logic [3:0]        mem_mask;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_data_in;
  logic              mem_valid;
  logic [DATA_W-1:0] mem_data_out;

  // Arbiter side: consumes requests and memory replies, drives completions
  // and the memory command.
  modport slave (
    input  if_request, if_we_re, if_mask, if_address, if_data_in,
    output if_valid, if_err, if_data_out,
    input  dm_request, dm_we_re, dm_mask, dm_address, dm_data_in,
    output dm_valid, dm_err, dm_data_out,
    output mem_request, mem_we_re, mem_mask, mem_address, mem_data_in,
    input  mem_valid, mem_data_out
  );

  // Environment side: requesters plus memory model.
  modport master (
    output if_request, if_we_re, if_mask, if_address, if_data_in,
    input  if_valid, if_err, if_data_out,
    output dm_request, dm_we_re, dm_mask, dm_address, dm_data_in,
    input  dm_valid, dm_err, dm_data_out,
    input  mem_request, mem_we_re, mem_mask, mem_address, mem_data_in,
    output mem_valid, mem_data_out
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter onto one shared memory with a wait timeout.
// Define ARB_RR_EN for round-robin on simultaneous requests; default is fixed DM priority.
module mem_arbiter #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15
) (
  input logic         clk,
  input logic         rst,
  mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_DM = 2'd2
  } state_t;

  // Timeout fires in the BUSY cycle where the counter would reach TIMEOUT.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t            state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [3:0]        mask_q, mask_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  logic busy, tmo, done, pick_dm;

`ifdef ARB_RR_EN
  logic ptr_dm_q, ptr_dm_d;
  assign pick_dm = bus.dm_request & (~bus.if_request | ptr_dm_q);
`else
  assign pick_dm = bus.dm_request;
`endif

  assign busy = (state_q != IDLE);
  assign tmo  = busy & ~bus.mem_valid & (cnt_q == CNT_LAST);
  assign done = busy & (bus.mem_valid | tmo);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    we_d    = we_q;
    mask_d  = mask_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
`ifdef ARB_RR_EN
    ptr_dm_d = ptr_dm_q;
`endif
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        req_d = 1'b0;
        if (bus.if_request | bus.dm_request) begin
          req_d = 1'b1;
          if (pick_dm) begin
            state_d = BUSY_DM;
            we_d    = bus.dm_we_re;
            mask_d  = bus.dm_mask;
            addr_d  = bus.dm_address;
            wdata_d = bus.dm_data_in;
`ifdef ARB_RR_EN
            ptr_dm_d = 1'b0;
`endif
          end else begin
            state_d = BUSY_IF;
            we_d    = bus.if_we_re;
            mask_d  = bus.if_mask;
            addr_d  = bus.if_address;
            wdata_d = bus.if_data_in;
`ifdef ARB_RR_EN
            ptr_dm_d = 1'b1;
`endif
          end
        end
      end
      BUSY_IF, BUSY_DM: begin
        if (done) begin
          state_d = IDLE;
          req_d   = 1'b0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      mask_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      we_q    <= we_d;
      mask_q  <= mask_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

`ifdef ARB_RR_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_dm_q <= 1'b1;
    else     ptr_dm_q <= ptr_dm_d;
  end
`endif

  assign bus.mem_request = req_q;
  assign bus.mem_we_re   = we_q;
  assign bus.mem_mask    = mask_q;
  assign bus.mem_address = addr_q;
  assign bus.mem_data_in = wdata_q;

  // Completions are combinational on mem_valid; read data is zero unless a reply lands.
  assign bus.if_valid    = done & (state_q == BUSY_IF);
  assign bus.if_err      = tmo  & (state_q == BUSY_IF);
  assign bus.if_data_out = ((state_q == BUSY_IF) & bus.mem_valid) ? bus.mem_data_out : '0;
  assign bus.dm_valid    = done & (state_q == BUSY_DM);
  assign bus.dm_err      = tmo  & (state_q == BUSY_DM);
  assign bus.dm_data_out = ((state_q == BUSY_DM) & bus.mem_valid) ? bus.mem_data_out : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed table, corner sequences and
// randomized traffic against a transaction-level reference model.
module tb_mem_arbiter;
  localparam int ADDR_W  = 8;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 15;
`ifdef ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus();

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_vec = 0;
  int n_bad = 0;

  // Reference model: one outstanding transaction, timed by absolute cycle index.
  int          cyc;
  bit          m_busy, m_dm, m_last_dm;
  logic        m_we;
  logic [3:0]  m_mask;
  logic [7:0]  m_addr;
  logic [31:0] m_wdata;
  int          m_start;

  typedef struct {
    logic ifr; logic [7:0] ia;
    logic dmr; logic dwe; logic [7:0] da; logic [31:0] dd;
    logic mv;  logic [31:0] md;
    logic e_req; logic [7:0] e_addr; logic e_we;
    logic e_iv; logic e_dv; logic [31:0] e_id; logic [31:0] e_dd;
  } vec_t;

  vec_t tbl [12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", nm, cyc, act, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.if_request = 1'b0; bus.if_we_re = 1'b0; bus.if_mask = 4'h0;
    bus.if_address = 8'h00; bus.if_data_in = 32'h0;
    bus.dm_request = 1'b0; bus.dm_we_re = 1'b0; bus.dm_mask = 4'h0;
    bus.dm_address = 8'h00; bus.dm_data_in = 32'h0;
    bus.mem_valid = 1'b0; bus.mem_data_out = 32'h0;
  endtask

  task automatic model_reset();
    m_busy = 1'b0; m_dm = 1'b0; m_last_dm = 1'b0;
    m_we = 1'b0; m_mask = 4'h0; m_addr = 8'h00; m_wdata = 32'h0; m_start = 0;
  endtask

  // Sample at the falling edge and compare every output with the model.
  task automatic sample();
    bit ok, tmo, v;
    logic [31:0] d;
    @(negedge clk);
    ok  = m_busy && bus.mem_valid;
    tmo = m_busy && !bus.mem_valid && ((cyc - m_start) == TIMEOUT - 1);
    v   = ok || tmo;
    d   = ok ? bus.mem_data_out : 32'h0;
    chk("mem_request", 32'(bus.mem_request), 32'(m_busy));
    chk("mem_we_re",   32'(bus.mem_we_re),   32'(m_we));
    chk("mem_mask",    32'(bus.mem_mask),    32'(m_mask));
    chk("mem_address", 32'(bus.mem_address), 32'(m_addr));
    chk("mem_data_in", bus.mem_data_in,      m_wdata);
    chk("if_valid",    32'(bus.if_valid),    32'(v && !m_dm));
    chk("if_err",      32'(bus.if_err),      32'(tmo && !m_dm));
    chk("if_data_out", bus.if_data_out,      (v && !m_dm) ? d : 32'h0);
    chk("dm_valid",    32'(bus.dm_valid),    32'(v && m_dm));
    chk("dm_err",      32'(bus.dm_err),      32'(tmo && m_dm));
    chk("dm_data_out", bus.dm_data_out,      (v && m_dm) ? d : 32'h0);
  endtask

  // Advance the model by one cycle with the current inputs, then the clock.
  task automatic advance();
    bit pick;
    if (m_busy) begin
      if (bus.mem_valid || ((cyc - m_start) == TIMEOUT - 1)) m_busy = 1'b0;
    end else if (bus.if_request || bus.dm_request) begin
      pick = bus.dm_request && (!bus.if_request || !(RR && m_last_dm));
      m_dm = pick; m_last_dm = pick; m_busy = 1'b1; m_start = cyc + 1;
      m_we    = pick ? bus.dm_we_re   : bus.if_we_re;
      m_mask  = pick ? bus.dm_mask    : bus.if_mask;
      m_addr  = pick ? bus.dm_address : bus.if_address;
      m_wdata = pick ? bus.dm_data_in : bus.if_data_in;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    model_reset();
    #1;
    chk("rst_mem_request", 32'(bus.mem_request), 32'h0);
    chk("rst_dm_valid",    32'(bus.dm_valid),    32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc = 0;
  endtask

  initial begin
    logic [7:0] grants[$];
    logic       prev;
    logic [7:0] exp_g;
    int         pct;

    tbl[0]  = '{1, 8'h04, 0, 0, 8'h00, 32'h0,        0, 32'h0,        0, 8'h00, 0, 0, 0, 32'h0,        32'h0};
    tbl[1]  = '{0, 8'h00, 0, 0, 8'h00, 32'h0,        0, 32'h0,        1, 8'h04, 0, 0, 0, 32'h0,        32'h0};
    tbl[2]  = '{0, 8'h00, 0, 0, 8'h00, 32'h0,        0, 32'h0,        1, 8'h04, 0, 0, 0, 32'h0,        32'h0};
    tbl[3]  = '{0, 8'h00, 0, 0, 8'h00, 32'h0,        1, 32'h00500093, 1, 8'h04, 0, 1, 0, 32'h00500093, 32'h0};
    tbl[4]  = '{0, 8'h00, 0, 0, 8'h00, 32'h0,        0, 32'h0,        0, 8'h00, 0, 0, 0, 32'h0,        32'h0};
    tbl[5]  = '{1, 8'h20, 1, 1, 8'h10, 32'hDEADBEEF, 0, 32'h0,        0, 8'h00, 0, 0, 0, 32'h0,        32'h0};
    tbl[6]  = '{1, 8'h20, 0, 0, 8'h00, 32'h0,        0, 32'h0,        1, 8'h10, 1, 0, 0, 32'h0,        32'h0};
    tbl[7]  = '{1, 8'h20, 0, 0, 8'h00, 32'h0,        1, 32'h11111111, 1, 8'h10, 1, 0, 1, 32'h0,        32'h11111111};
    tbl[8]  = '{1, 8'h20, 0, 0, 8'h00, 32'h0,        0, 32'h0,        0, 8'h00, 0, 0, 0, 32'h0,        32'h0};
    tbl[9]  = '{0, 8'h00, 0, 0, 8'h00, 32'h0,        0, 32'h0,        1, 8'h20, 0, 0, 0, 32'h0,        32'h0};
    tbl[10] = '{0, 8'h00, 0, 0, 8'h00, 32'h0,        1, 32'hCAFEF00D, 1, 8'h20, 0, 1, 0, 32'hCAFEF00D, 32'h0};
    tbl[11] = '{0, 8'h00, 0, 0, 8'h00, 32'h0,        1, 32'h12345678, 0, 8'h00, 0, 0, 0, 32'h0,        32'h0};

    // Asynchronous reset visible before any clock edge.
    cyc = 0;
    idle_inputs();
    rst = 1'b1;
    model_reset();
    #2;
    chk("async_rst_mem_request", 32'(bus.mem_request), 32'h0);
    chk("async_rst_mem_address", 32'(bus.mem_address), 32'h0);
    chk("async_rst_if_valid",    32'(bus.if_valid),    32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc = 0;

    // Directed table: single IF read, simultaneous IF/DM, mem_valid in IDLE.
    for (int i = 0; i < 12; i++) begin
      bus.if_request = tbl[i].ifr; bus.if_address = tbl[i].ia;
      bus.dm_request = tbl[i].dmr; bus.dm_we_re = tbl[i].dwe; bus.dm_mask = 4'hF;
      bus.dm_address = tbl[i].da;  bus.dm_data_in = tbl[i].dd;
      bus.mem_valid  = tbl[i].mv;  bus.mem_data_out = tbl[i].md;
      sample();
      chk("tbl_mem_request", 32'(bus.mem_request), 32'(tbl[i].e_req));
      if (tbl[i].e_req) begin
        chk("tbl_mem_address", 32'(bus.mem_address), 32'(tbl[i].e_addr));
        chk("tbl_mem_we_re",   32'(bus.mem_we_re),   32'(tbl[i].e_we));
      end
      chk("tbl_if_valid",    32'(bus.if_valid), 32'(tbl[i].e_iv));
      chk("tbl_dm_valid",    32'(bus.dm_valid), 32'(tbl[i].e_dv));
      chk("tbl_if_data_out", bus.if_data_out,   tbl[i].e_id);
      chk("tbl_dm_data_out", bus.dm_data_out,   tbl[i].e_dd);
      advance();
    end

    // Grant order with both ports requesting continuously.
    do_reset();
    bus.if_request = 1'b1; bus.if_address = 8'hA1;
    bus.dm_request = 1'b1; bus.dm_address = 8'hD1;
    bus.mem_valid = 1'b1; bus.mem_data_out = 32'h0BADF00D;
    prev = 1'b0;
    for (int c = 0; c < 20; c++) begin
      sample();
      if (bus.mem_request && !prev) grants.push_back(bus.mem_address);
      prev = bus.mem_request;
      advance();
    end
    chk("grant_count_ge4", 32'(grants.size() >= 4), 32'h1);
    for (int i = 0; i < 4 && i < grants.size(); i++) begin
      exp_g = (RR && (i % 2 == 1)) ? 8'hA1 : 8'hD1;
      chk("grant_order", 32'(grants[i]), 32'(exp_g));
    end

    // Timeout with silent memory, then mem_valid colliding with timeout.
    for (int variant = 0; variant < 2; variant++) begin
      do_reset();
      bus.dm_request = 1'b1; bus.dm_address = 8'h44;
      sample();
      advance();
      bus.dm_request = 1'b0;
      for (int k = 1; k <= 16; k++) begin
        bus.mem_valid    = (variant == 1) && (k == 15);
        bus.mem_data_out = 32'h5A5A5A5A;
        sample();
        chk("tmo_mem_request", 32'(bus.mem_request), 32'(k <= 15));
        chk("tmo_dm_valid",    32'(bus.dm_valid),    32'(k == 15));
        chk("tmo_dm_err",      32'(bus.dm_err),      32'((k == 15) && (variant == 0)));
        chk("tmo_dm_data_out", bus.dm_data_out,
            ((k == 15) && (variant == 1)) ? 32'h5A5A5A5A : 32'h0);
        chk("tmo_if_valid",    32'(bus.if_valid),    32'h0);
        advance();
      end
    end

    // Reset in the middle of an IF transaction, memory replying afterwards.
    do_reset();
    bus.if_request = 1'b1; bus.if_address = 8'h33;
    sample();
    advance();
    bus.if_request = 1'b0;
    sample();
    chk("midrst_busy_mem_request", 32'(bus.mem_request), 32'h1);
    advance();
    bus.mem_valid = 1'b1; bus.mem_data_out = 32'h77777777;
    rst = 1'b1;
    model_reset();
    #1;
    chk("midrst_mem_request", 32'(bus.mem_request), 32'h0);
    chk("midrst_if_valid",    32'(bus.if_valid),    32'h0);
    @(negedge clk);
    rst = 1'b0;
    advance();
    for (int k = 0; k < 3; k++) begin
      sample();
      chk("postrst_if_valid",    32'(bus.if_valid),    32'h0);
      chk("postrst_mem_request", 32'(bus.mem_request), 32'h0);
      advance();
    end

    // Randomized traffic; alternate chatty and near-silent memory phases.
    do_reset();
    for (int c = 0; c < 800; c++) begin
      pct = ((c / 100) % 2 == 0) ? 40 : 3;
      bus.if_request   = 1'($urandom_range(0, 1));
      bus.if_we_re     = 1'($urandom);
      bus.if_mask      = 4'($urandom);
      bus.if_address   = 8'($urandom);
      bus.if_data_in   = $urandom;
      bus.dm_request   = 1'($urandom_range(0, 1));
      bus.dm_we_re     = 1'($urandom);
      bus.dm_mask      = 4'($urandom);
      bus.dm_address   = 8'($urandom);
      bus.dm_data_in   = $urandom;
      bus.mem_valid    = ($urandom_range(0, 99) < pct);
      bus.mem_data_out = $urandom;
      sample();
      advance();
    end

    idle_inputs();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
